// File: rtl/sb_unpack_ctrl.sv
// Sequencing controller for the synapse-buffer weight unpacker (ping-pong row load, shift/sign/zero controls).
// Optional macro SB_UNPACK_CTRL_ZE_EN: build the zb register and drive o_ze from the latched zb count.
module sb_unpack_ctrl #(
   parameter int N          = 16,
   parameter int SHIFT_BITS = 5,
   parameter int CNT_BITS   = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [SHIFT_BITS-1:0] i_cfg_n,
   input  logic [CNT_BITS-1:0]   i_cfg_count,
   input  logic                  i_cfg_signed,
   input  logic [SHIFT_BITS-2:0] i_cfg_zb,
   input  logic                  i_row_valid,
   output logic                  o_row_ready,
   output logic [1:0]            o_load,
   output logic [SHIFT_BITS-1:0] o_s,
   output logic [SHIFT_BITS-2:0] o_n,
   output logic [N-1:0]          o_se,
   output logic [N-1:0]          o_ze,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int AW = SHIFT_BITS + 1;
   localparam int BW = CNT_BITS + SHIFT_BITS;
   localparam logic [AW-1:0] N_AW = AW'(N);
   localparam logic [BW-1:0] N_BW = BW'(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state, state_nxt;
   logic [SHIFT_BITS-1:0] n_q;
   logic                  sgn_q;
   logic [SHIFT_BITS-1:0] ptr;
   logic [AW-1:0]         avail;
   logic                  wr_half;
   logic [CNT_BITS-1:0]   wleft;
   logic [BW-1:0]         bits_left;
   logic [AW-1:0]         n_ext;
   logic                  row_acc;
   logic                  w_acc;
   logic                  start_acc;

   assign n_ext     = {1'b0, n_q};
   assign start_acc = (state == IDLE) && i_start;

   // Ready/valid depend only on registered state so handshakes never form combinational loops.
   assign o_row_ready = (state == RUN) && (avail <= N_AW) && (bits_left != '0);
   assign o_valid     = (state == RUN) && (avail >= n_ext) && (wleft != '0);
   assign row_acc     = o_row_ready && i_row_valid;
   assign w_acc       = o_valid && i_ready;

   assign o_s = ptr;
   assign o_n = n_q[SHIFT_BITS-2:0];

   always_comb begin
      state_nxt = state;
      o_load    = '0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      if (row_acc) o_load[wr_half] = 1'b1;
      case (state)
         IDLE: begin
            if (i_start) state_nxt = (i_cfg_count == '0) ? DONE : RUN;
         end
         RUN: begin
            o_busy = 1'b1;
            if (w_acc && (wleft == CNT_BITS'(1))) state_nxt = DONE;
         end
         DONE: begin
            o_busy    = 1'b1;
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         n_q       <= '0;
         sgn_q     <= 1'b0;
         ptr       <= '0;
         avail     <= '0;
         wr_half   <= 1'b0;
         wleft     <= '0;
         bits_left <= '0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            n_q       <= i_cfg_n;
            sgn_q     <= i_cfg_signed;
            ptr       <= '0;
            avail     <= '0;
            wr_half   <= 1'b0;
            wleft     <= i_cfg_count;
            bits_left <= BW'(i_cfg_count) * BW'(i_cfg_n);
         end else begin
            if (row_acc) begin
               wr_half   <= ~wr_half;
               bits_left <= (bits_left > N_BW) ? bits_left - N_BW : '0;
            end
            if (w_acc) begin
               // ptr is SHIFT_BITS wide, so the add wraps modulo 2N for free.
               ptr   <= ptr + n_q;
               wleft <= wleft - CNT_BITS'(1);
            end
            avail <= avail + (row_acc ? N_AW : '0) - (w_acc ? n_ext : '0);
         end
      end
   end

   always_comb begin
      o_se = '0;
      for (int unsigned i = 0; i < N; i++) begin
         o_se[i] = sgn_q && (SHIFT_BITS'(i) >= n_q);
      end
   end

`ifdef SB_UNPACK_CTRL_ZE_EN
   logic [SHIFT_BITS-2:0] zb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zb_q <= '0;
      end else if (start_acc) begin
         zb_q <= i_cfg_zb;
      end
   end

   always_comb begin
      o_ze = '1;
      for (int unsigned i = 0; i < N; i++) begin
         o_ze[i] = !(SHIFT_BITS'(i) < {1'b0, zb_q});
      end
   end
`else
   logic unused_zb;
   assign unused_zb = ^i_cfg_zb;
   assign o_ze      = '1;
`endif

endmodule

// File: tb/tb_sb_unpack_ctrl.sv
// Self-checking bench for sb_unpack_ctrl: random row data and handshake gating checked against a
// bit-stream reference (rows loaded vs. bits consumed) plus an unpacker register model.
module tb_sb_unpack_ctrl;

   localparam int N  = 16;
   localparam int SB = 5;
   localparam int CB = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [SB-1:0] i_cfg_n;
   logic [CB-1:0] i_cfg_count;
   logic          i_cfg_signed;
   logic [SB-2:0] i_cfg_zb;
   logic          i_row_valid;
   logic          o_row_ready;
   logic [1:0]    o_load;
   logic [SB-1:0] o_s;
   logic [SB-2:0] o_n;
   logic [N-1:0]  o_se;
   logic [N-1:0]  o_ze;
   logic          o_valid;
   logic          i_ready;
   logic          o_busy;
   logic          o_done;

   logic [N-1:0]  row_in;
   logic [N-1:0]  ls_m;
   logic [N-1:0]  ms_m;
   logic [N-1:0]  stream[$];

   int n_checks = 0;
   int n_fail   = 0;

   sb_unpack_ctrl #(.N(N), .SHIFT_BITS(SB), .CNT_BITS(CB)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_n(i_cfg_n),
      .i_cfg_count(i_cfg_count), .i_cfg_signed(i_cfg_signed), .i_cfg_zb(i_cfg_zb),
      .i_row_valid(i_row_valid), .o_row_ready(o_row_ready), .o_load(o_load),
      .o_s(o_s), .o_n(o_n), .o_se(o_se), .o_ze(o_ze), .o_valid(o_valid),
      .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 clk = ~clk;

   // Unpacker ping-pong register driven by the DUT's half strobes.
   always @(posedge clk) begin
      if (o_load[0]) ls_m <= row_in;
      if (o_load[1]) ms_m <= row_in;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_checks(input string pfx);
      check({pfx, "_row_ready"}, o_row_ready, 0);
      check({pfx, "_load"},      o_load, 0);
      check({pfx, "_s"},         o_s, 0);
      check({pfx, "_valid"},     o_valid, 0);
      check({pfx, "_busy"},      o_busy, 0);
      check({pfx, "_done"},      o_done, 0);
      check({pfx, "_se"},        o_se, 0);
      check({pfx, "_ze"},        o_ze, 32'hFFFF);
   endtask

   // gate: 0 = always valid/ready, 1 = ready toggles and row_valid low every third cycle, 2 = random
   task automatic run(input int n, input int cnt, input bit sgn, input int zb, input int gate,
                      input int abort_at);
      int            rows, k, cyc, total_rows, loaded, sh, b;
      bit            exp_rr, exp_v;
      logic [31:0]   reg32, rot, expw, mask;
      logic [N-1:0]  exp_se, exp_ze, tmp;
      stream.delete();
      total_rows = (cnt * n + N - 1) / N;
      for (int r = 0; r <= total_rows; r++) begin
         tmp = 16'($urandom);
         stream.push_back(tmp);
      end
      exp_se = sgn ? 16'(32'hFFFF << n) : 16'h0000;
`ifdef SB_UNPACK_CTRL_ZE_EN
      exp_ze = 16'(32'hFFFF << zb);
`else
      exp_ze = 16'hFFFF;
`endif
      @(negedge clk);
      i_start      = 1'b1;
      i_cfg_n      = 5'(n);
      i_cfg_count  = 12'(cnt);
      i_cfg_signed = sgn;
      i_cfg_zb     = 4'(zb);
      i_row_valid  = 1'b0;
      i_ready      = 1'b0;
      #1;
      check("idle_busy", o_busy, 0);
      check("idle_row_ready", o_row_ready, 0);
      @(negedge clk);
      i_start      = 1'b0;
      i_cfg_n      = 5'($urandom);
      i_cfg_count  = 12'($urandom);
      i_cfg_signed = 1'($urandom);
      i_cfg_zb     = 4'($urandom);
      if (cnt == 0) begin
         #1;
         check("zero_done", o_done, 1);
         check("zero_busy", o_busy, 1);
         check("zero_row_ready", o_row_ready, 0);
         check("zero_valid", o_valid, 0);
         @(negedge clk);
         #1;
         check("zero_done_after", o_done, 0);
         check("zero_busy_after", o_busy, 0);
         check("zero_valid_after", o_valid, 0);
         return;
      end
      rows = 0;
      k    = 0;
      cyc  = 0;
      while (k < cnt && cyc < 3000) begin
         if (abort_at >= 0 && k == abort_at) break;
         case (gate)
            0:       begin i_row_valid = 1'b1; i_ready = 1'b1; end
            1:       begin i_row_valid = (cyc % 3) != 2; i_ready = (cyc % 2) == 0; end
            default: begin i_row_valid = $urandom_range(2) != 0; i_ready = 1'($urandom); end
         endcase
         i_start  = 1'($urandom);
         i_cfg_n  = 5'($urandom);
         row_in   = stream[rows];
         #1;
         loaded = rows * N - k * n;
         exp_rr = (loaded <= N) && (rows * N < cnt * n);
         exp_v  = (loaded >= n) && (k < cnt);
         check("row_ready", o_row_ready, exp_rr);
         check("valid", o_valid, exp_v);
         check("busy", o_busy, 1);
         check("done", o_done, 0);
         check("se", o_se, exp_se);
         check("ze", o_ze, exp_ze);
         check("n", o_n, n % 16);
         if (exp_rr && i_row_valid) begin
            check("load", o_load, (rows % 2) ? 2 : 1);
            rows++;
         end else begin
            check("load_idle", o_load, 0);
         end
         if (exp_v && i_ready) begin
            sh = (k * n) % (2 * N);
            check("s", o_s, sh);
            reg32 = {ms_m, ls_m};
            rot   = (reg32 >> sh) | (reg32 << (32 - sh));
            mask  = (32'h1 << n) - 32'h1;
            expw  = '0;
            for (int j = 0; j < n; j++) begin
               b = k * n + j;
               tmp = stream[b / N];
               expw[j] = tmp[b % N];
            end
            check("weight", rot & mask, expw);
            k++;
         end
         cyc++;
         @(negedge clk);
      end
      i_start     = 1'b0;
      i_row_valid = 1'b0;
      i_ready     = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         reset_checks("abort");
         @(negedge clk);
         rst = 1'b0;
         #1;
         check("abort_no_done", o_done, 0);
         check("abort_busy", o_busy, 0);
         return;
      end
      check("weights_in_budget", k, cnt);
      #1;
      check("end_done", o_done, 1);
      check("end_busy", o_busy, 1);
      check("end_valid", o_valid, 0);
      check("end_row_ready", o_row_ready, 0);
      check("end_load", o_load, 0);
      @(negedge clk);
      #1;
      check("idle_done", o_done, 0);
      check("idle_busy_after", o_busy, 0);
   endtask

   initial begin
      int n;
      rst          = 1'b1;
      i_start      = 1'b0;
      i_cfg_n      = '0;
      i_cfg_count  = '0;
      i_cfg_signed = 1'b0;
      i_cfg_zb     = '0;
      i_row_valid  = 1'b0;
      i_ready      = 1'b0;
      row_in       = '0;
      repeat (2) @(negedge clk);
      #1;
      reset_checks("reset");
      @(negedge clk);
      rst = 1'b0;

      run(16, 3, 1'b0, 0, 0, -1);
      run(5, 7, 1'b1, 2, 0, -1);
      run(7, 10, 1'b0, 3, 1, -1);
      run(7, 10, 1'b0, 3, 0, -1);
      run(4, 0, 1'b1, 1, 0, -1);
      run(5, 10, 1'b1, 1, 0, 2);
      run(5, 4, 1'b1, 0, 0, -1);
      run(1, 40, 1'b1, 0, 2, -1);
      run(16, 9, 1'b1, 15, 2, -1);
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(16, 1);
         run(n, $urandom_range(50, 1), 1'($urandom), $urandom_range(n - 1, 0), 2, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
